init_reset_sequencer: RTL and testbench

- Consumes the device init-monitor outputs (FABRIC_POR_N, DEVICE_INIT_DONE, per-bank VDDI status), plus PLL lock and an external reset request.
- Produces NUM_STAGES staggered, synchronous, active-low fabric reset releases for downstream domains (e.g. ADC, DSP, comms).
- Holds all domains in reset until every qualifier has been stable for STABLE_CYCLES.
- Re-asserts all resets whenever a qualifier drops.

---
 rtl/init_reset_sequencer.sv | 177 +++++++++++++++++
 tb/tb_init_reset_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/init_reset_sequencer.sv
// Staggered fabric reset release: qualifies the init-monitor, supply, PLL and
// external reset inputs, then releases NUM_STAGES active-low resets in order.
module init_reset_sequencer #(
    parameter int NUM_BANKS     = 7,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGE_GAP     = 16,
    parameter int NUM_STAGES    = 3
) (
    input  logic                  CLK,
    input  logic                  FABRIC_POR_N,
    input  logic                  DEVICE_INIT_DONE,
    input  logic [NUM_BANKS-1:0]  BANK_VDDI_STATUS,
    input  logic                  PLL_LOCK,
    input  logic                  EXT_RST_N,
    output logic [NUM_STAGES-1:0] RESET_N_OUT,
    output logic                  READY,
    output logic [1:0]            SEQ_STATE,
    output logic [7:0]            DROP_COUNT
);

    localparam int NUM_QUAL = NUM_BANKS + 3;
    localparam int CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int GAP_W    = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int STG_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(NUM_STAGES - 1);
    localparam logic [STG_W-1:0] STG_ONE  = STG_W'(1);

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_STABLE  = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } seq_state_t;

    logic [NUM_QUAL-1:0] qual_raw;
    logic [NUM_QUAL-1:0] sync_q [SYNC_STAGES];
    logic                ok_s;

    seq_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [STG_W-1:0]    stage_q, stage_d;
    logic [NUM_STAGES-1:0] rst_q, rst_d;
    logic                ready_q, ready_d;
    logic [7:0]          drop_q, drop_d;

    assign qual_raw = {EXT_RST_N, PLL_LOCK, BANK_VDDI_STATUS, DEVICE_INIT_DONE};

    // Every qualifier gets its own chain; all chains clear to "not good".
    always_ff @(posedge CLK or negedge FABRIC_POR_N) begin
        if (!FABRIC_POR_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= qual_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign ok_s = &sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge FABRIC_POR_N) begin
        if (!FABRIC_POR_N) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
            gap_q   <= '0;
            stage_q <= '0;
            rst_q   <= '0;
            ready_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            stage_q <= stage_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        stage_d = stage_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        drop_d  = drop_q;

        case (state_q)
            S_WAIT: begin
                rst_d   = '0;
                ready_d = 1'b0;
                if (ok_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end
            end

            S_STABLE: begin
                if (!ok_s) begin
                    state_d = S_WAIT;
                end else if (cnt_q == CNT_LAST) begin
                    rst_d[0] = 1'b1;
                    gap_d    = '0;
                    if (NUM_STAGES == 1) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = S_RELEASE;
                        stage_d = STG_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_RELEASE: begin
                if (!ok_s) begin
                    state_d = S_WAIT;
                    rst_d   = '0;
                    ready_d = 1'b0;
                    if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end else if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    // Only the stage pointed at is released, so order is kept.
                    for (int i = 1; i < NUM_STAGES; i++) begin
                        if (stage_q == STG_W'(i)) begin
                            rst_d[i] = 1'b1;
                        end
                    end
                    if (stage_q == STG_LAST) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                    end else begin
                        stage_d = stage_q + 1'b1;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            S_RUN: begin
                if (!ok_s) begin
                    state_d = S_WAIT;
                    rst_d   = '0;
                    ready_d = 1'b0;
                    if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d = S_WAIT;
                rst_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    assign RESET_N_OUT = rst_q;
    assign READY       = ready_q;
    assign SEQ_STATE   = state_q;
    assign DROP_COUNT  = drop_q;

endmodule

// File: tb/tb_init_reset_sequencer.sv
// Bench for init_reset_sequencer: vector table, directed corner sequences and
// random qualifier drops checked against a run-length reference model.
module tb_init_reset_sequencer;

    localparam int NB    = 7;
    localparam int SS    = 2;
    localparam int SC    = 8;
    localparam int SG    = 4;
    localparam int NS    = 3;
    localparam int NQ    = NB + 3;
    localparam int REL_R = SC + 1;
    localparam int RUN_R = REL_R + (NS - 1) * SG;

    localparam logic [NQ-1:0] Q_ALL  = '1;
    localparam logic [NQ-1:0] Q_BANK4 = Q_ALL & ~(NQ'(1) << 5);
    localparam logic [NQ-1:0] Q_PLL  = Q_ALL & ~(NQ'(1) << (NB + 1));
    localparam logic [NQ-1:0] Q_EXT  = Q_ALL & ~(NQ'(1) << (NB + 2));

    logic           clk = 1'b0;
    logic           por_n = 1'b1;
    logic [NQ-1:0]  quals = '0;
    logic [NS-1:0]  reset_n_out;
    logic           ready;
    logic [1:0]     seq_state;
    logic [7:0]     drop_count;
    logic [13:0]    dut_out;

    int errors = 0;
    int checks = 0;
    int edge_no = 0;
    logic watch = 1'b0;
    logic seen1 = 1'b0;

    logic ok_pipe[$];
    int   run_len;
    int   m_drop;

    typedef struct {
        int            edge_i;
        logic [NQ-1:0] q;
        logic [NS-1:0] rst;
        logic          rdy;
        logic [1:0]    st;
        logic [7:0]    drop;
    } vec_t;

    vec_t vecs[20];

    init_reset_sequencer #(
        .NUM_BANKS(NB), .SYNC_STAGES(SS), .STABLE_CYCLES(SC),
        .STAGE_GAP(SG), .NUM_STAGES(NS)
    ) dut (
        .CLK(clk),
        .FABRIC_POR_N(por_n),
        .DEVICE_INIT_DONE(quals[0]),
        .BANK_VDDI_STATUS(quals[NB:1]),
        .PLL_LOCK(quals[NB+1]),
        .EXT_RST_N(quals[NB+2]),
        .RESET_N_OUT(reset_n_out),
        .READY(ready),
        .SEQ_STATE(seq_state),
        .DROP_COUNT(drop_count)
    );

    assign dut_out = {reset_n_out, ready, seq_state, drop_count};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: the sequencer's outputs depend only on how many consecutive
    // edges the synchronised qualifiers have all been good.
    task automatic model_reset();
        ok_pipe.delete();
        for (int i = 0; i < SS; i++) ok_pipe.push_back(1'b0);
        run_len = 0;
        m_drop  = 0;
    endtask

    task automatic model_edge();
        logic ok_s;
        if (!por_n) begin
            model_reset();
            return;
        end
        ok_s = ok_pipe.pop_front();
        ok_pipe.push_back(&quals);
        if (ok_s) begin
            if (run_len < 100000) run_len++;
        end else begin
            if (run_len >= REL_R && m_drop < 255) m_drop++;
            run_len = 0;
        end
    endtask

    function automatic logic [13:0] model_out();
        logic [NS-1:0] r;
        logic          rd;
        logic [1:0]    st;
        for (int k = 0; k < NS; k++) r[k] = (run_len >= REL_R + k * SG);
        rd = (run_len >= RUN_R);
        if (run_len == 0)          st = 2'd0;
        else if (run_len < REL_R)  st = 2'd1;
        else if (run_len < RUN_R)  st = 2'd2;
        else                       st = 2'd3;
        return {r, rd, st, 8'(m_drop)};
    endfunction

    always @(posedge clk) begin
        model_edge();
        #1;
        check("model", dut_out, model_out());
        if (watch && reset_n_out[1]) seen1 = 1'b1;
        edge_no++;
    end

    task automatic run_to(input int k);
        wait (edge_no > k);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        por_n = 1'b0;
        quals = Q_ALL;
        model_reset();
        #1 check("reset_hold", dut_out, '0);
        repeat (2) @(negedge clk);
        por_n   = 1'b1;
        edge_no = 0;
    endtask

    task automatic hold(input logic [NQ-1:0] q, input int n);
        quals = q;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [NQ-1:0] mask;
        int bad_left;

        model_reset();
        #2 por_n = 1'b0;
        #1 check("reset_state", dut_out, '0);

        // Scenario 1 and 3: release timing, then a RUN drop and re-release.
        vecs[0]  = '{0,  Q_ALL,   3'b000, 1'b0, 2'd0, 8'd0};
        vecs[1]  = '{1,  Q_ALL,   3'b000, 1'b0, 2'd0, 8'd0};
        vecs[2]  = '{2,  Q_ALL,   3'b000, 1'b0, 2'd1, 8'd0};
        vecs[3]  = '{9,  Q_ALL,   3'b000, 1'b0, 2'd1, 8'd0};
        vecs[4]  = '{10, Q_ALL,   3'b001, 1'b0, 2'd2, 8'd0};
        vecs[5]  = '{13, Q_ALL,   3'b001, 1'b0, 2'd2, 8'd0};
        vecs[6]  = '{14, Q_ALL,   3'b011, 1'b0, 2'd2, 8'd0};
        vecs[7]  = '{17, Q_ALL,   3'b011, 1'b0, 2'd2, 8'd0};
        vecs[8]  = '{18, Q_ALL,   3'b111, 1'b1, 2'd3, 8'd0};
        vecs[9]  = '{20, Q_ALL,   3'b111, 1'b1, 2'd3, 8'd0};
        vecs[10] = '{21, Q_BANK4, 3'b111, 1'b1, 2'd3, 8'd0};
        vecs[11] = '{22, Q_BANK4, 3'b111, 1'b1, 2'd3, 8'd0};
        vecs[12] = '{23, Q_BANK4, 3'b000, 1'b0, 2'd0, 8'd1};
        vecs[13] = '{24, Q_ALL,   3'b000, 1'b0, 2'd0, 8'd1};
        vecs[14] = '{26, Q_ALL,   3'b000, 1'b0, 2'd1, 8'd1};
        vecs[15] = '{33, Q_ALL,   3'b000, 1'b0, 2'd1, 8'd1};
        vecs[16] = '{34, Q_ALL,   3'b001, 1'b0, 2'd2, 8'd1};
        vecs[17] = '{38, Q_ALL,   3'b011, 1'b0, 2'd2, 8'd1};
        vecs[18] = '{41, Q_ALL,   3'b011, 1'b0, 2'd2, 8'd1};
        vecs[19] = '{42, Q_ALL,   3'b111, 1'b1, 2'd3, 8'd1};

        do_reset();
        for (int i = 0; i < 20; i++) begin
            run_to(vecs[i].edge_i - 1);
            if (clk) @(negedge clk);
            quals = vecs[i].q;
            run_to(vecs[i].edge_i);
            check($sformatf("vec%0d", i), dut_out,
                  {vecs[i].rst, vecs[i].rdy, vecs[i].st, vecs[i].drop});
        end

        // Scenario 5: asynchronous clear mid-RUN, between clock edges.
        run_to(44);
        #2;
        por_n = 1'b0;
        model_reset();
        #1 check("por_async", dut_out, '0);

        // Scenario 2: PLL_LOCK drop during STABLE restarts qualification.
        do_reset();
        quals = Q_ALL;
        run_to(7);
        check("s2_stable", dut_out, {3'b000, 1'b0, 2'd1, 8'd0});
        @(negedge clk);
        quals = Q_PLL;
        run_to(10);
        check("s2_wait", dut_out, {3'b000, 1'b0, 2'd0, 8'd0});
        @(negedge clk);
        quals = Q_ALL;
        run_to(20);
        check("s2_requal", dut_out, {3'b000, 1'b0, 2'd1, 8'd0});
        run_to(21);
        check("s2_release", dut_out, {3'b001, 1'b0, 2'd2, 8'd0});

        // Scenario 4: EXT_RST_N drop with only stage 0 released.
        do_reset();
        quals = Q_ALL;
        run_to(10);
        check("s4_rel0", dut_out, {3'b001, 1'b0, 2'd2, 8'd0});
        @(negedge clk);
        quals = Q_EXT;
        seen1 = 1'b0;
        watch = 1'b1;
        run_to(12);
        check("s4_before", dut_out, {3'b001, 1'b0, 2'd2, 8'd0});
        run_to(13);
        check("s4_drop", dut_out, {3'b000, 1'b0, 2'd0, 8'd1});
        run_to(20);
        watch = 1'b0;
        check("s4_no_stage1", {13'd0, seen1}, 14'd0);
        @(negedge clk);
        quals = Q_ALL;

        // Scenario 6: 300 drops from RUN saturate the drop counter.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            hold(Q_ALL, $urandom_range(RUN_R, RUN_R + 7));
            mask = '0;
            mask[$urandom_range(0, NQ - 1)] = 1'b1;
            hold(Q_ALL & ~mask, $urandom_range(2, 3));
        end
        hold(Q_ALL, 6);
        check("s6_saturate", {6'd0, drop_count}, 14'd255);

        // Random qualifier glitches of 1-4 cycles against the model.
        do_reset();
        bad_left = 0;
        mask = '0;
        for (int i = 0; i < 2500; i++) begin
            if (bad_left > 0) begin
                bad_left--;
            end else begin
                mask = '0;
                if ($urandom_range(0, 29) == 0) begin
                    mask[$urandom_range(0, NQ - 1)] = 1'b1;
                    bad_left = $urandom_range(0, 3);
                end
            end
            hold(Q_ALL & ~mask, 1);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
